// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// bytes per memory word and the width of the image length header.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_WIDTH      = 16;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler. Keeps the three most recent bytes
// plus a 2-bit byte counter; word_out presents the word formed with the
// byte being shifted in this cycle, so the caller can capture a complete
// word on the same edge that accepts its last byte.
module byte_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [23:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for shift register and byte counter; clear wins over shift.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = 24'd0;
      cnt_d  = 2'd0;
    end else if (shift_en) begin
      word_d = {byte_in, word_q[23:8]};
      cnt_d  = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= 24'd0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_out  = {byte_in, word_q};
  assign word_full = shift_en && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed image from a byte interface into data memory,
// holding the CPU in reset until the whole image has been written.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e                 state_q, state_d;
  logic                   len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0]   n_q, n_d;
  logic [LEN_WIDTH-1:0]   k_q, k_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            adr_q, adr_d;
  logic                   byte_ready_q, byte_ready_d;
  logic                   mem_write_q, mem_write_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   cpu_reset_q, cpu_reset_d;

  logic                   accept_s;
  logic                   asm_clear_s;
  logic                   asm_shift_s;
  logic [31:0]            asm_word_s;
  logic                   asm_full_s;
  logic [LEN_WIDTH-1:0]   n_new_s;

  assign accept_s = byte_valid && byte_ready_q;
  // Second header byte is the high half; first one sits just below it.
  assign n_new_s  = asm_word_s[31:16];

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear_s),
    .shift_en  (asm_shift_s),
    .byte_in   (byte_data),
    .word_out  (asm_word_s),
    .word_full (asm_full_s)
  );

  // FSM next state, counters, write capture and assembler control.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    n_d         = n_q;
    k_d         = k_q;
    wdata_d     = wdata_q;
    adr_d       = adr_q;
    asm_clear_s = 1'b0;
    asm_shift_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LEN;
          len_hi_d    = 1'b0;
          k_d         = 16'd0;
          asm_clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          asm_shift_s = 1'b1;
          if (!len_hi_q) begin
            len_hi_d = 1'b1;
          end else begin
            n_d         = n_new_s;
            asm_clear_s = 1'b1;
            if (n_new_s == 16'd0) begin
              state_d = ST_DONE;
            end else if ({16'd0, n_new_s} > 32'(MAX_WORDS)) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_DATA;
            end
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          asm_shift_s = 1'b1;
          if (asm_full_s) begin
            state_d = ST_WRITE;
            wdata_d = asm_word_s;
            adr_d   = BASE_ADDR + {14'd0, k_q, 2'b00};
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (({1'b0, k_q} + 17'd1) < {1'b0, n_q}) begin
          k_d     = k_q + 16'd1;
          state_d = ST_DATA;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the next state so they register with it.
  always_comb begin
    byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
    mem_write_d  = (state_d == ST_WRITE);
    busy_d       = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
    err_d        = (state_d == ST_ERROR);
    cpu_reset_d  = (state_d != ST_DONE);
  end

  // All state and output registers; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= 1'b0;
      n_q          <= 16'd0;
      k_q          <= 16'd0;
      wdata_q      <= 32'd0;
      adr_q        <= 32'd0;
      byte_ready_q <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      n_q          <= n_d;
      k_q          <= k_d;
      wdata_q      <= wdata_d;
      adr_q        <= adr_d;
      byte_ready_q <= byte_ready_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  assign byte_ready    = byte_ready_q;
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_WriteData = wdata_q;
  assign Ext_DataAdr   = adr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cpu_reset     = cpu_reset_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected writes are queued when the image
// bytes are driven and compared by a write monitor as the DUT issues them.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, Ext_MemWrite, cpu_reset, busy, done, err;
  logic [31:0] Ext_WriteData, Ext_DataAdr;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          wr0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [31:0] word;

  boot_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_WriteData (Ext_WriteData),
    .Ext_DataAdr   (Ext_DataAdr),
    .cpu_reset     (cpu_reset),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (Ext_MemWrite === 1'b1) begin
      wr_cnt++;
      check_b("ready_during_write", byte_ready, 1'b0);
      check_b("write_was_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check_w("write_addr", Ext_DataAdr, exp_e[63:32]);
        check_w("write_data", Ext_WriteData, exp_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_b("byte_accept", byte_ready, 1'b1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_byte_ready"}, byte_ready, 1'b0);
    check_b({tag, "_memwrite"}, Ext_MemWrite, 1'b0);
    check_w({tag, "_wdata"}, Ext_WriteData, 32'h0);
    check_w({tag, "_adr"}, Ext_DataAdr, 32'h0);
    check_b({tag, "_busy"}, busy, 1'b0);
    check_b({tag, "_done"}, done, 1'b0);
    check_b({tag, "_err"}, err, 1'b0);
    check_b({tag, "_cpu_reset"}, cpu_reset, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Two-word image, no gaps.
    pulse_start();
    check_b("t1_busy", busy, 1'b1);
    check_b("t1_ready", byte_ready, 1'b1);
    exp_q.push_back({32'h0000_0000, 32'h0050_0013});
    exp_q.push_back({32'h0000_0004, 32'h0010_0093});
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h0050_0013, 0);
    send_word(32'h0010_0093, 0);
    @(negedge clk);
    check_b("t1_done_in_write", done, 1'b0);
    @(negedge clk);
    check_b("t1_done", done, 1'b1);
    check_b("t1_cpu_reset", cpu_reset, 1'b0);
    check_b("t1_busy_end", busy, 1'b0);
    check_w("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    check_w("t1_hold_data", Ext_WriteData, 32'h0010_0093);
    check_w("t1_hold_adr", Ext_DataAdr, 32'h0000_0004);

    // Empty image.
    wr0 = wr_cnt;
    pulse_start();
    check_b("t2_cpu_reset_rise", cpu_reset, 1'b1);
    check_b("t2_done_clear", done, 1'b0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check_b("t2_done", done, 1'b1);
    check_b("t2_cpu_reset", cpu_reset, 1'b0);
    check_w("t2_no_writes", 32'(wr_cnt), 32'(wr0));

    // Oversized image: N = 65.
    pulse_start();
    send_byte(8'h41, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check_b("t3_err", err, 1'b1);
    check_b("t3_cpu_reset", cpu_reset, 1'b1);
    check_b("t3_busy", busy, 1'b0);
    byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      check_b("t3_not_ready", byte_ready, 1'b0);
    end
    byte_valid = 1'b0;
    check_b("t3_err_hold", err, 1'b1);
    check_w("t3_no_writes", 32'(wr_cnt), 32'(wr0));
    pulse_start();
    check_b("t3_err_clear", err, 1'b0);
    check_b("t3_busy_again", busy, 1'b1);

    // Reset in the middle of a word, then a fresh one-word load.
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    pulse_start();
    exp_q.push_back({32'h0000_0000, 32'hDDCC_BBAA});
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'hDDCC_BBAA, 0);
    @(negedge clk); @(negedge clk);
    check_b("t4_done", done, 1'b1);
    check_w("t4_wr_cnt", 32'(wr_cnt), 32'(wr0 + 1));

    // Largest accepted image: N = MAX_WORDS = 64.
    pulse_start();
    send_byte(8'h40, 0); send_byte(8'h00, 0);
    for (int w = 0; w < 64; w++) begin
      word = {8'(w), 8'(~w), 8'(w * 3), 8'hA5};
      exp_q.push_back({32'(w * 4), word});
      send_word(word, 0);
    end
    @(negedge clk); @(negedge clk);
    check_b("t5_done", done, 1'b1);
    check_b("t5_err", err, 1'b0);
    check_w("t5_wr_cnt", 32'(wr_cnt), 32'(wr0 + 65));

    // Random gaps plus an ignored start pulse during DATA.
    pulse_start();
    exp_q.push_back({32'h0000_0000, 32'h0050_0013});
    exp_q.push_back({32'h0000_0004, 32'h0010_0093});
    send_byte(8'h02, $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'h13, $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
    pulse_start();
    check_b("t6_busy_after_start", busy, 1'b1);
    check_b("t6_ready_after_start", byte_ready, 1'b1);
    send_byte(8'h50, $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
    send_word(32'h0010_0093, 3);
    @(negedge clk); @(negedge clk);
    check_b("t6_done", done, 1'b1);
    check_b("t6_cpu_reset", cpu_reset, 1'b0);
    check_w("t6_wr_cnt", 32'(wr_cnt), 32'(wr0 + 67));
    check_w("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
